// File: rtl/sound_glu.sv
// sound_glu: host register window onto a DOC sound chip and its wave RAM.
// A single sequencer arbitrates between DOC wave fetches (priority) and
// one queued host data access, driving either the wave RAM port or the
// DOC register strobes.
//
// state | meaning
// IDLE  | no access in flight; picks wave fetch first, then queued host op
// WAVE  | wave RAM read for the DOC, waiting for ram_ack_i
// HRAM  | host read/write of wave RAM at the pointer, waiting for ram_ack_i
// HDOC  | host read/write of a DOC register, doc_cs_n_o held low for a fixed count
module sound_glu #(
  parameter int DOC_ACCESS_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        host_strobe_i,
  input  logic        host_we_i,
  input  logic [1:0]  host_addr_i,
  input  logic [7:0]  host_data_i,
  output logic [7:0]  host_data_o,
  output logic        doc_cs_n_o,
  output logic        doc_we_n_o,
  output logic [7:0]  doc_addr_o,
  output logic [7:0]  doc_data_o,
  input  logic [7:0]  doc_data_i,
  output logic [15:0] ram_addr_o,
  output logic        ram_rd_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_wdata_o,
  input  logic [7:0]  ram_rdata_i,
  input  logic        ram_ack_i,
  input  logic [15:0] wave_address_i,
  input  logic        wave_rd_i,
  output logic        wave_data_ready_o,
  output logic [7:0]  wave_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAVE, S_HRAM, S_HDOC} state_t;

  localparam logic [3:0] DOC_LAST = 4'(DOC_ACCESS_CYCLES - 1);

  state_t      r_state;
  logic        r_busy;
  logic        r_ram_sel;
  logic        r_auto_inc;
  logic [3:0]  r_volume;
  logic [15:0] r_ptr;
  logic [7:0]  r_data;
  logic        r_op_pending;
  logic        r_op_we;
  logic        r_op_ram;
  logic        r_wave_pending;
  logic [15:0] r_wave_addr;
  logic [3:0]  r_cnt;
  logic        r_doc_cs_n;
  logic        r_doc_we_n;
  logic [7:0]  r_doc_addr;
  logic [7:0]  r_doc_data;
  logic [15:0] r_ram_addr;
  logic        r_ram_rd;
  logic        r_ram_wr;
  logic [7:0]  r_ram_wdata;
  logic        r_wave_ready;
  logic [7:0]  r_wave_data;

  wire         w_data_access = host_strobe_i && (host_addr_i == 2'd1) && !r_busy;
  wire         w_wave_accept = wave_rd_i && !r_wave_pending && (r_state != S_WAVE);

  // Host register file, pending request slots and the access sequencer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_ram_sel      <= 1'b0;
      r_auto_inc     <= 1'b0;
      r_volume       <= 4'd0;
      r_ptr          <= 16'd0;
      r_data         <= 8'd0;
      r_op_pending   <= 1'b0;
      r_op_we        <= 1'b0;
      r_op_ram       <= 1'b0;
      r_wave_pending <= 1'b0;
      r_wave_addr    <= 16'd0;
      r_cnt          <= 4'd0;
      r_doc_cs_n     <= 1'b1;
      r_doc_we_n     <= 1'b1;
      r_doc_addr     <= 8'd0;
      r_doc_data     <= 8'd0;
      r_ram_addr     <= 16'd0;
      r_ram_rd       <= 1'b0;
      r_ram_wr       <= 1'b0;
      r_ram_wdata    <= 8'd0;
      r_wave_ready   <= 1'b0;
      r_wave_data    <= 8'd0;
    end else begin
      r_wave_ready <= 1'b0;

      if (w_wave_accept) begin
        r_wave_pending <= 1'b1;
        r_wave_addr    <= wave_address_i;
      end

      case (r_state)
        S_IDLE: begin
          if (r_wave_pending) begin
            r_wave_pending <= 1'b0;
            r_ram_addr     <= r_wave_addr;
            r_ram_rd       <= 1'b1;
            r_state        <= S_WAVE;
          end else if (r_op_pending) begin
            r_op_pending <= 1'b0;
            if (r_op_ram) begin
              r_ram_addr  <= r_ptr;
              r_ram_wdata <= r_data;
              r_ram_rd    <= !r_op_we;
              r_ram_wr    <= r_op_we;
              r_state     <= S_HRAM;
            end else begin
              r_doc_addr <= r_ptr[7:0];
              r_doc_data <= r_data;
              r_doc_cs_n <= 1'b0;
              r_doc_we_n <= !r_op_we;
              r_cnt      <= DOC_LAST;
              r_state    <= S_HDOC;
            end
          end
        end
        S_WAVE: begin
          if (ram_ack_i) begin
            r_ram_rd     <= 1'b0;
            r_wave_data  <= ram_rdata_i;
            r_wave_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_HRAM: begin
          if (ram_ack_i) begin
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            if (!r_op_we) r_data <= ram_rdata_i;
            r_busy  <= 1'b0;
            if (r_auto_inc) r_ptr <= r_ptr + 16'd1;
            r_state <= S_IDLE;
          end
        end
        S_HDOC: begin
          if (r_cnt == 4'd0) begin
            r_doc_cs_n <= 1'b1;
            r_doc_we_n <= 1'b1;
            if (!r_op_we) r_data <= doc_data_i;
            r_busy  <= 1'b0;
            if (r_auto_inc) r_ptr <= r_ptr + 16'd1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Host writes come last so an explicit pointer write beats auto-increment.
      if (host_strobe_i && host_we_i) begin
        case (host_addr_i)
          2'd0: begin
            r_ram_sel  <= host_data_i[6];
            r_auto_inc <= host_data_i[5];
            r_volume   <= host_data_i[3:0];
          end
          2'd2: r_ptr[7:0]  <= host_data_i;
          2'd3: r_ptr[15:8] <= host_data_i;
          default: ;
        endcase
      end

      if (w_data_access) begin
        r_busy       <= 1'b1;
        r_op_pending <= 1'b1;
        r_op_we      <= host_we_i;
        r_op_ram     <= r_ram_sel;
        if (host_we_i) r_data <= host_data_i;
      end
    end
  end

  // Combinational read-back of the selected host register.
  always_comb begin
    host_data_o = 8'd0;
    case (host_addr_i)
      2'd0: host_data_o = {r_busy, r_ram_sel, r_auto_inc, 1'b0, r_volume};
      2'd1: host_data_o = r_data;
      2'd2: host_data_o = r_ptr[7:0];
      2'd3: host_data_o = r_ptr[15:8];
      default: host_data_o = 8'd0;
    endcase
  end

  assign doc_cs_n_o        = r_doc_cs_n;
  assign doc_we_n_o        = r_doc_we_n;
  assign doc_addr_o        = r_doc_addr;
  assign doc_data_o        = r_doc_data;
  assign ram_addr_o        = r_ram_addr;
  assign ram_rd_o          = r_ram_rd;
  assign ram_wr_o          = r_ram_wr;
  assign ram_wdata_o       = r_ram_wdata;
  assign wave_data_ready_o = r_wave_ready;
  assign wave_data_o       = r_wave_data;

endmodule

// File: tb/tb_sound_glu.sv
// tb_sound_glu: directed bench for sound_glu with a RAM responder, a DOC
// strobe monitor and scoreboard queues for wave fetches and RAM writes.
module tb_sound_glu;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        host_strobe_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [1:0]  host_addr_i = 2'd0;
  logic [7:0]  host_data_i = 8'd0;
  logic [7:0]  host_data_o;
  logic        doc_cs_n_o, doc_we_n_o;
  logic [7:0]  doc_addr_o, doc_data_o;
  logic [7:0]  doc_data_i = 8'd0;
  logic [15:0] ram_addr_o;
  logic        ram_rd_o, ram_wr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i;
  logic        ram_ack_i = 1'b0;
  logic [15:0] wave_address_i = 16'd0;
  logic        wave_rd_i = 1'b0;
  logic        wave_data_ready_o;
  logic [7:0]  wave_data_o;

  sound_glu #(.DOC_ACCESS_CYCLES(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .host_strobe_i(host_strobe_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_data_i(host_data_i), .host_data_o(host_data_o),
    .doc_cs_n_o(doc_cs_n_o), .doc_we_n_o(doc_we_n_o),
    .doc_addr_o(doc_addr_o), .doc_data_o(doc_data_o), .doc_data_i(doc_data_i),
    .ram_addr_o(ram_addr_o), .ram_rd_o(ram_rd_o), .ram_wr_o(ram_wr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
    .wave_address_i(wave_address_i), .wave_rd_i(wave_rd_i),
    .wave_data_ready_o(wave_data_ready_o), .wave_data_o(wave_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Wave RAM contents: a fixed function of the address.
  assign ram_rdata_i = ram_addr_o[7:0] ^ ram_addr_o[15:8] ^ 8'h5A;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_ready = 0;
  int n_wr = 0;
  int last_ready_cyc = 0;
  int last_wr_cyc = 0;
  int last_len = 0;
  int sc = 0;
  int cs_len = 0;
  int ack_dly = 2;
  logic force_ack = 1'b0;
  logic [7:0]  exp_doc_addr = 8'd0;
  logic        exp_doc_we_n = 1'b1;
  logic [7:0]  exp_doc_wdata = 8'd0;
  logic [7:0]  wq[$];
  logic [23:0] wrq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs just after the edge and respond as RAM/DOC.
  task automatic step();
    logic [7:0]  we8;
    logic [23:0] ew;
    @(posedge clk_i); #1;
    cyc++;
    if (wave_data_ready_o) begin
      n_ready++;
      last_ready_cyc = cyc;
      if (wq.size() == 0) chk("wave_unexpected", 32'd1, 32'd0);
      else begin
        we8 = wq.pop_front();
        chk("wave_data", wave_data_o, we8);
      end
    end
    if (!doc_cs_n_o) begin
      cs_len++;
      chk("doc_addr", doc_addr_o, exp_doc_addr);
      chk("doc_we_n", doc_we_n_o, exp_doc_we_n);
      if (!doc_we_n_o) chk("doc_wdata", doc_data_o, exp_doc_wdata);
    end else if (cs_len != 0) begin
      chk("doc_cs_len", cs_len, 32'd2);
      cs_len = 0;
    end
    ram_ack_i = force_ack;
    if (ram_rd_o || ram_wr_o) begin
      sc++;
      if (ack_dly != 0 && sc == ack_dly) begin
        ram_ack_i = 1'b1;
        last_len = sc;
        if (ram_wr_o) begin
          n_wr++;
          last_wr_cyc = cyc;
          if (wrq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
          else begin
            ew = wrq.pop_front();
            chk("ram_wr", {ram_addr_o, ram_wdata_o}, ew);
          end
        end
      end
    end else begin
      sc = 0;
    end
  endtask

  task automatic host(input logic we, input logic [1:0] a, input logic [7:0] d);
    host_strobe_i = 1'b1; host_we_i = we; host_addr_i = a; host_data_i = d;
    step();
    host_strobe_i = 1'b0; host_we_i = 1'b0;
  endtask

  task automatic host_rd(output logic [7:0] v);
    host_strobe_i = 1'b1; host_we_i = 1'b0; host_addr_i = 2'd1;
    #1 v = host_data_o;
    step();
    host_strobe_i = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
    host_addr_i = a;
    #1 v = host_data_o;
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] v;
    int k;
    k = 0;
    rd_reg(2'd0, v);
    while (v[7] && k < 200) begin
      step(); k++;
      rd_reg(2'd0, v);
    end
    chk({tag, "_idle"}, v[7], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int nw, nr, k;

    // Reset state
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    step();
    chk("rst_cs_n", doc_cs_n_o, 1'b1);
    chk("rst_we_n", doc_we_n_o, 1'b1);
    chk("rst_ram_rd", ram_rd_o, 1'b0);
    chk("rst_ram_wr", ram_wr_o, 1'b0);
    chk("rst_ready", wave_data_ready_o, 1'b0);
    chk("rst_wdata", wave_data_o, 8'h00);
    rd_reg(2'd0, v); chk("rst_ctrl", v, 8'h00);
    rd_reg(2'd1, v); chk("rst_data", v, 8'h00);
    rd_reg(2'd2, v); chk("rst_ptr_lo", v, 8'h00);
    rd_reg(2'd3, v); chk("rst_ptr_hi", v, 8'h00);

    // Control write masking, then RAM write with auto-increment carry
    host(1'b1, 2'd0, 8'hFF);
    rd_reg(2'd0, v); chk("ctrl_mask", v, 8'h6F);
    host(1'b1, 2'd0, 8'h60);
    host(1'b1, 2'd2, 8'hFF);
    host(1'b1, 2'd3, 8'h12);
    rd_reg(2'd2, v); chk("ptr_lo", v, 8'hFF);
    rd_reg(2'd3, v); chk("ptr_hi", v, 8'h12);
    ack_dly = 3;
    wrq.push_back({16'h12FF, 8'hAB});
    host(1'b1, 2'd1, 8'hAB);
    rd_reg(2'd0, v); chk("busy_set", v, 8'hE0);
    wait_idle("wr1");
    chk("wr1_len", last_len, 32'd3);
    rd_reg(2'd2, v); chk("wr1_ptr_lo", v, 8'h00);
    rd_reg(2'd3, v); chk("wr1_ptr_hi", v, 8'h13);
    rd_reg(2'd1, v); chk("wr1_data", v, 8'hAB);

    // Data write while busy is dropped
    step();
    nw = n_wr;
    wrq.push_back({16'h1300, 8'h11});
    host(1'b1, 2'd1, 8'h11);
    host(1'b1, 2'd1, 8'h22);
    wait_idle("drop");
    for (int i = 0; i < 5; i++) step();
    chk("drop_nwr", n_wr - nw, 32'd1);
    rd_reg(2'd1, v); chk("drop_data", v, 8'h11);
    rd_reg(2'd2, v); chk("drop_ptr_lo", v, 8'h01);
    rd_reg(2'd3, v); chk("drop_ptr_hi", v, 8'h13);

    // Simultaneous wave request and host RAM write: wave first
    step();
    nr = n_ready;
    ack_dly = 2;
    wq.push_back(8'h1A);
    wrq.push_back({16'h1301, 8'h77});
    wave_rd_i = 1'b1; wave_address_i = 16'h4000;
    host(1'b1, 2'd1, 8'h77);
    wave_rd_i = 1'b0;
    wait_idle("prio");
    step(); step();
    chk("prio_order", (last_ready_cyc < last_wr_cyc), 1'b1);
    chk("prio_pulses", n_ready - nr, 32'd1);

    // Pointer wrap on RAM read with auto-increment, one-read lag
    host(1'b1, 2'd2, 8'hFF);
    host(1'b1, 2'd3, 8'hFF);
    ack_dly = 1;
    host_rd(v); chk("wrap_lag", v, 8'h77);
    wait_idle("wrap");
    rd_reg(2'd2, v); chk("wrap_ptr_lo", v, 8'h00);
    rd_reg(2'd3, v); chk("wrap_ptr_hi", v, 8'h00);
    rd_reg(2'd1, v); chk("wrap_data", v, 8'h5A);

    // DOC reads with one-read lag
    step();
    host(1'b1, 2'd0, 8'h00);
    host(1'b1, 2'd2, 8'hA0);
    exp_doc_addr = 8'hA0; exp_doc_we_n = 1'b1;
    doc_data_i = 8'h55;
    host_rd(v); chk("doc_rd1", v, 8'h5A);
    wait_idle("doc1");
    doc_data_i = 8'h66;
    host_rd(v); chk("doc_rd2", v, 8'h55);
    wait_idle("doc2");
    rd_reg(2'd1, v); chk("doc_rd3", v, 8'h66);
    rd_reg(2'd2, v); chk("doc_ptr_lo", v, 8'hA0);

    // DOC write; wave request arrives mid-access, second pulse dropped,
    // control write accepted while busy
    step();
    exp_doc_we_n = 1'b0; exp_doc_wdata = 8'h3C;
    nr = n_ready;
    ack_dly = 2;
    wq.push_back(8'h7C);
    host(1'b1, 2'd1, 8'h3C);
    wave_rd_i = 1'b1; wave_address_i = 16'h1234;
    step();
    wave_address_i = 16'h5555;
    host(1'b1, 2'd0, 8'h05);
    wave_rd_i = 1'b0;
    rd_reg(2'd0, v); chk("ctrl_busy_wr", v, 8'h85);
    wait_idle("docw");
    k = 0;
    while (n_ready == nr && k < 20) begin step(); k++; end
    chk("late_wave_served", (n_ready != nr), 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("late_wave_pulses", n_ready - nr, 32'd1);
    rd_reg(2'd1, v); chk("docw_data", v, 8'h3C);

    // Reset during HRAM with ack pending
    step();
    host(1'b1, 2'd0, 8'h60);
    host(1'b1, 2'd2, 8'h00);
    host(1'b1, 2'd3, 8'h20);
    ack_dly = 0;
    host(1'b1, 2'd1, 8'h99);
    step(); step();
    chk("abort_wr_held", ram_wr_o, 1'b1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("abort_wr", ram_wr_o, 1'b0);
    chk("abort_wdata", wave_data_o, 8'h00);
    chk("abort_ready", wave_data_ready_o, 1'b0);
    rd_reg(2'd0, v); chk("abort_ctrl", v, 8'h00);
    rd_reg(2'd2, v); chk("abort_ptr_lo", v, 8'h00);
    rd_reg(2'd1, v); chk("abort_data", v, 8'h00);
    force_ack = 1'b1;
    step(); step();
    force_ack = 1'b0;
    step();
    chk("late_ack_wr", ram_wr_o, 1'b0);
    chk("late_ack_rd", ram_rd_o, 1'b0);
    chk("late_ack_ready", wave_data_ready_o, 1'b0);
    rd_reg(2'd0, v); chk("late_ack_ctrl", v, 8'h00);
    rd_reg(2'd2, v); chk("late_ack_ptr_lo", v, 8'h00);

    chk("wq_empty", wq.size(), 32'd0);
    chk("wrq_empty", wrq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
